// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter between a boot loader and a CPU fetch port.
// Optional loader anti-starvation force-grant is built when IMEM_ARB_STARVE_EN is defined.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_BOOT  | loader owns memory, CPU stalled, every loader request granted
// ST_RUN   | shared memory, CPU has priority, loader uses idle CPU cycles
// ST_DRAIN | one cycle to retire the in-flight access before BOOT
module imem_arbiter #(
  parameter int ADDR_W     = 6,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rstn,
  // CPU fetch port
  input  logic              cpu_req,
  input  logic [31:0]       cpu_addr,
  output logic              cpu_stall,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_rvalid,
  // loader port
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [31:0]       ldr_addr,
  input  logic [31:0]       ldr_wdata,
  input  logic              ldr_done,
  input  logic              ldr_halt,
  output logic              ldr_gnt,
  output logic [31:0]       ldr_rdata,
  output logic              ldr_rvalid,
  // memory port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              addr_err
);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        cpu_gnt;
  logic        ldr_gnt_int;
  logic        force_gnt;
  logic        any_gnt;
  logic [31:0] gnt_addr;
  logic        cpu_rvalid_q;
  logic        ldr_rvalid_q;
  logic        addr_err_q, addr_err_d;
  logic        unused_addr_hi;

`ifdef IMEM_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_q, starve_d;

  assign force_gnt = (state_q == ST_RUN) && ldr_req &&
                     (starve_q == CNT_W'(STARVE_MAX));

  // Counts consecutive RUN cycles in which a loader request was refused.
  always_comb begin
    starve_d = '0;
    if ((state_q == ST_RUN) && ldr_req && !ldr_gnt_int) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic unused_starve_max;

  assign unused_starve_max = (STARVE_MAX == 0);
  assign force_gnt         = 1'b0;
`endif

  // Grants are gated by rstn so no memory access can start during reset.
  always_comb begin
    cpu_gnt     = 1'b0;
    ldr_gnt_int = 1'b0;
    cpu_stall   = 1'b1;
    if (rstn) begin
      case (state_q)
        ST_RUN: begin
          cpu_gnt     = cpu_req && !force_gnt;
          ldr_gnt_int = ldr_req && (!cpu_req || force_gnt);
          cpu_stall   = ldr_gnt_int;
        end
        default: begin
          ldr_gnt_int = ldr_req;
        end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: begin
        if (ldr_done) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (ldr_halt) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_d = ST_BOOT;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  assign any_gnt  = cpu_gnt | ldr_gnt_int;
  assign gnt_addr = cpu_gnt ? cpu_addr : ldr_addr;

  always_comb begin
    addr_err_d = addr_err_q;
    if (any_gnt && (gnt_addr[1:0] != 2'b00)) begin
      addr_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_BOOT;
      cpu_rvalid_q <= 1'b0;
      ldr_rvalid_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cpu_rvalid_q <= cpu_gnt;
      ldr_rvalid_q <= ldr_gnt_int & ~ldr_we;
      addr_err_q   <= addr_err_d;
    end
  end

  // Upper address bits are dropped on purpose: accesses wrap modulo the depth.
  assign unused_addr_hi = ^gnt_addr[31:ADDR_W+2];

  assign mem_en    = any_gnt;
  assign mem_we    = ldr_gnt_int & ldr_we;
  assign mem_addr  = gnt_addr[ADDR_W+1:2];
  assign mem_wdata = ldr_wdata;

  assign ldr_gnt    = ldr_gnt_int;
  assign cpu_rvalid = cpu_rvalid_q;
  assign ldr_rvalid = ldr_rvalid_q;
  assign cpu_rdata  = cpu_rvalid_q ? mem_rdata : 32'h0;
  assign ldr_rdata  = ldr_rvalid_q ? mem_rdata : 32'h0;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized bench for imem_arbiter against a cycle-level reference model.
// The starvation scenario follows IMEM_ARB_STARVE_EN when it is defined.
module tb_imem_arbiter;

  localparam int ADDR_W     = 6;
  localparam int DEPTH      = 64;
  localparam int STARVE_MAX = 8;
`ifdef IMEM_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  typedef enum int {M_BOOT, M_RUN, M_DRAIN} mode_t;

  logic              clk = 1'b0;
  logic              rstn;
  logic              cpu_req;
  logic [31:0]       cpu_addr;
  logic              cpu_stall;
  logic [31:0]       cpu_rdata;
  logic              cpu_rvalid;
  logic              ldr_req;
  logic              ldr_we;
  logic [31:0]       ldr_addr;
  logic [31:0]       ldr_wdata;
  logic              ldr_done;
  logic              ldr_halt;
  logic              ldr_gnt;
  logic [31:0]       ldr_rdata;
  logic              ldr_rvalid;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              addr_err;

  logic [31:0] phys [DEPTH];

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  mode_t       m_mode;
  int          m_wait;
  logic        m_crv, m_lrv, m_err;
  logic [31:0] m_cdata, m_ldata;
  logic [31:0] ref_mem [DEPTH];

  imem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rstn(rstn),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_stall(cpu_stall),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_done(ldr_done), .ldr_halt(ldr_halt), .ldr_gnt(ldr_gnt),
    .ldr_rdata(ldr_rdata), .ldr_rvalid(ldr_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  // synchronous single-port memory with one-cycle read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) phys[mem_addr] <= mem_wdata;
      mem_rdata <= phys[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_BOOT;
    m_wait = 0;
    m_crv  = 1'b0;
    m_lrv  = 1'b0;
    m_err  = 1'b0;
  endtask

  // One clock cycle: drive inputs just after a rising edge, check before the next, advance model.
  task automatic cycle(input logic creq, input logic [31:0] caddr,
                       input logic lreq, input logic lwe, input logic [31:0] laddr,
                       input logic [31:0] lwdata, input logic done, input logic halt);
    logic        e_cg, e_lg, e_stall, frc;
    logic [31:0] ga;
    int          w;
    cpu_req = creq; cpu_addr = caddr;
    ldr_req = lreq; ldr_we = lwe; ldr_addr = laddr; ldr_wdata = lwdata;
    ldr_done = done; ldr_halt = halt;
    if (m_mode != M_RUN) begin
      e_cg = 1'b0; e_lg = lreq; e_stall = 1'b1;
    end else begin
      frc     = STARVE_ON && lreq && (m_wait >= STARVE_MAX);
      e_cg    = creq && !frc;
      e_lg    = lreq && (!creq || frc);
      e_stall = e_lg;
    end
    ga = e_cg ? caddr : laddr;
    w  = int'(ga[ADDR_W+1:2]);
    #3;
    chk("ldr_gnt", 32'(ldr_gnt), 32'(e_lg));
    chk("cpu_stall", 32'(cpu_stall), 32'(e_stall));
    chk("mem_en", 32'(mem_en), 32'(e_cg | e_lg));
    chk("mem_we", 32'(mem_we), 32'(e_lg & lwe));
    if (e_cg | e_lg) chk("mem_addr", 32'(mem_addr), 32'(w));
    if (e_lg & lwe) chk("mem_wdata", mem_wdata, lwdata);
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_crv));
    chk("ldr_rvalid", 32'(ldr_rvalid), 32'(m_lrv));
    if (m_crv) chk("cpu_rdata", cpu_rdata, m_cdata);
    if (m_lrv) chk("ldr_rdata", ldr_rdata, m_ldata);
    chk("addr_err", 32'(addr_err), 32'(m_err));
    @(posedge clk);
    #1;
    if ((e_cg | e_lg) && (ga[1:0] != 2'b00)) m_err = 1'b1;
    m_crv = e_cg;
    if (e_cg) m_cdata = ref_mem[w];
    m_lrv = e_lg && !lwe;
    if (m_lrv) m_ldata = ref_mem[w];
    if (e_lg && lwe) ref_mem[w] = lwdata;
    m_wait = (m_mode == M_RUN && lreq && !e_lg) ? m_wait + 1 : 0;
    case (m_mode)
      M_BOOT:  if (done) m_mode = M_RUN;
      M_RUN:   if (halt) m_mode = M_DRAIN;
      default: m_mode = M_BOOT;
    endcase
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_stall"}, 32'(cpu_stall), 32'd1);
    chk({tag, "_cpu_rvalid"}, 32'(cpu_rvalid), 32'd0);
    chk({tag, "_ldr_rvalid"}, 32'(ldr_rvalid), 32'd0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
    chk({tag, "_ldr_rdata"}, ldr_rdata, 32'd0);
    chk({tag, "_addr_err"}, 32'(addr_err), 32'd0);
    chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [31:0] saved;
    rstn = 1'b0;
    cpu_req = 1'b0; cpu_addr = '0;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
    ldr_done = 1'b0; ldr_halt = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    rstn = 1'b1;

    // boot fill of the whole memory, then the boot word at 0x0
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'(i * 4), $urandom, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h2008_0005, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, $urandom & 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0);
    // done with a simultaneous write: serviced and RUN entered on the same edge
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h10, $urandom, 1'b1, 1'b0);

    cycle(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("boot_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("boot_rdata", cpu_rdata, 32'h2008_0005);

    // contention then first idle CPU cycle
    cycle(1'b1, 32'h4, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 32'h8, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0);
    chk("contend_ldr_rvalid", 32'(ldr_rvalid), 32'd1);

    // random aligned RUN traffic; ldr_done is ignored here
    for (int i = 0; i < 200; i++) begin
      a = $urandom & 32'hFFFF_FFFC;
      d = $urandom & 32'hFFFF_FFFC;
      cycle(1'($urandom), a, 1'($urandom), 1'($urandom), d, $urandom, 1'($urandom), 1'b0);
    end

    // starvation: both requests held high
    for (int i = 0; i < 2 * STARVE_MAX + 4; i++)
      cycle(1'b1, 32'(i * 4), 1'b1, 1'b0, 32'h3C, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // halt with a CPU read in flight
    cycle(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("halt_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("halt_rdata", cpu_rdata, ref_mem[8]);
    cycle(1'b1, 32'h24, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, 32'h24, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("boot_stall", 32'(cpu_stall), 32'd1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // misaligned, wrapped CPU read
    cycle(1'b1, 32'h102, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("misalign_err", 32'(addr_err), 32'd1);
    chk("misalign_rdata", cpu_rdata, ref_mem[0]);

    // fully random traffic including mode changes
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom, $urandom,
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
    end
    chk("err_sticky", 32'(addr_err), 32'd1);

    // reset during a loader write
    cpu_req = 1'b0; ldr_req = 1'b1; ldr_we = 1'b1;
    ldr_addr = 32'h14; ldr_wdata = ~ref_mem[5];
    saved = ref_mem[5];
    #1;
    rstn = 1'b0;
    #1;
    check_reset_outputs("rst_wr");
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    rstn = 1'b1;
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 1'b0);
    chk("rst_abort_data", ldr_rdata, saved);
    cycle(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, meaning word-index width of the instruction memory (64 words).
REQ-002 SHALL have parameter STARVE_MAX, default 8, meaning the maximum number of consecutive RUN cycles a loader request waits before it is force-granted.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have CPU fetch ports: cpu_req in 1, cpu_addr in 32 (byte address), cpu_stall out 1, cpu_rdata out 32, cpu_rvalid out 1.
REQ-006 SHALL have loader ports: ldr_req in 1, ldr_we in 1, ldr_addr in 32, ldr_wdata in 32, ldr_done in 1, ldr_halt in 1, ldr_gnt out 1, ldr_rdata out 32, ldr_rvalid out 1.
REQ-007 SHALL have memory ports: mem_en out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out 32, mem_rdata in 32 (registered one-cycle read).
REQ-008 SHALL have port addr_err, output, 1 bit: sticky flag for a misaligned granted address.

Function
REQ-009 SHALL implement three states: BOOT (loader owns memory), RUN (shared memory, CPU priority) and DRAIN (finish the in-flight access, then enter BOOT).
REQ-010 SHALL transition BOOT->RUN on ldr_done=1, RUN->DRAIN on ldr_halt=1, and DRAIN->BOOT after exactly one cycle.
REQ-011 SHALL, in BOOT and DRAIN, hold cpu_stall=1 and grant every loader request (ldr_gnt=ldr_req) combinationally.
REQ-012 SHALL, in RUN, grant the CPU when cpu_req=1 and grant the loader only when cpu_req=0 or a force-grant applies; cpu_stall=1 exactly in the cycles the loader is granted.
REQ-013 SHALL drive mem_en=1 in every granted cycle, mem_we=ldr_gnt&ldr_we, mem_addr=granted_addr[ADDR_W+1:2], and mem_wdata=ldr_wdata; upper address bits are ignored, so addresses wrap modulo the memory depth.
REQ-014 SHALL return read data with one-cycle latency: cpu_rvalid or ldr_rvalid is registered high on the cycle after a granted read by that owner, with rdata=mem_rdata; a write produces no rvalid.
REQ-015 SHALL set addr_err when a granted address has bits [1:0] nonzero; the access still proceeds word-aligned, and addr_err clears only on reset.
REQ-016 SHALL, on ldr_done and ldr_req in the same BOOT cycle, service the request and enter RUN on the same edge.
REQ-017 SHALL, on ldr_halt and cpu_req in the same RUN cycle, grant the CPU and return its rvalid during DRAIN.
REQ-018 SHALL ignore ldr_done outside BOOT and ldr_halt outside RUN.

Reset
REQ-019 SHALL, while rstn=0, force state=BOOT, cpu_stall=1, cpu_rvalid=0, ldr_rvalid=0, rdata outputs=0, addr_err=0 and the starve counter=0.
REQ-020 SHALL force mem_en=0 and mem_we=0 while rstn=0, so a write in progress is aborted with no write edge.
REQ-021 SHALL require rstn deassertion to be synchronous to clk at the system level; the first grant occurs on the first rising edge after release.

Configuration
REQ-022 SHALL, when IMEM_ARB_STARVE_EN is defined, count RUN cycles in which ldr_req=1 and ldr_gnt=0, and force-grant the loader for one cycle (CPU stalled) when the count reaches STARVE_MAX; the counter resets on any loader grant.
REQ-023 SHALL, when IMEM_ARB_STARVE_EN is undefined, contain no counter, and a RUN loader request waits indefinitely for cpu_req=0.

Verification
REQ-024 SHALL cover boot load: write 0x20080005 at address 0x0, pulse ldr_done, then CPU read at 0x0 -> cpu_rvalid one cycle later with cpu_rdata=0x20080005 and cpu_stall=0 in RUN.
REQ-025 SHALL cover contention: in RUN, cpu_req and ldr_req both high -> CPU granted, ldr_gnt=0; ldr_gnt=1 in the first cycle cpu_req=0.
REQ-026 SHALL cover starvation with the macro defined: cpu_req held high and ldr_req held high -> after 8 waiting cycles, one cycle with ldr_gnt=1 and cpu_stall=1, then the CPU resumes.
REQ-027 SHALL cover halt: ldr_halt while a CPU read is in flight -> cpu_rvalid in DRAIN, then BOOT with cpu_stall=1.
REQ-028 SHALL cover reset during a loader write: rstn low in the write cycle -> mem_we=0 immediately, state=BOOT and all outputs at reset values.
REQ-029 SHALL cover misalignment and wrap: CPU read at 0x102 -> mem_addr=0 and addr_err=1, remaining 1 until reset.
